exhaustive_vector_sweeper: RTL and testbench

// - Self-running exhaustive stimulus generator and checker for small combinational blocks (N-input, M-output).
// - Drives every one of the 2^N_IN input combinations onto the DUT, waits a settle time, and compares the DUT

---
 rtl/exhaustive_vector_sweeper.sv | 144 ++++++++++++++
 tb/tb_exhaustive_vector_sweeper.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_vector_sweeper.sv
// exhaustive_vector_sweeper
// Walks every input combination of a small combinational block, waits a
// programmable settle time per vector, then compares the DUT output against a
// golden-model output. It counts the mismatching vectors and remembers the
// first one that failed.
// Optional build macro: SWEEP_GRAY_EN applies the vectors in Gray-code order
// instead of ascending binary order. Cycle timing is the same in both builds.
module exhaustive_vector_sweeper #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [N_IN-1:0]   vec_out,
   input  logic [N_OUT-1:0]  dut_f,
   input  logic [N_OUT-1:0]  gold_f,
   output logic              busy,
   output logic              done,
   output logic [N_IN:0]     err_count,
   output logic              first_err_valid,
   output logic [N_IN-1:0]   first_err_vec
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [N_IN-1:0] IDX_LAST    = '1;
   localparam logic [7:0]      SETTLE_INIT = 8'(SETTLE);

   state_t            state;
   state_t            state_nx;
   logic [N_IN-1:0]   idx;
   logic [N_IN-1:0]   idx_nx;
   logic [N_IN-1:0]   idx_inc;
   logic [7:0]        settle_cnt;
   logic [7:0]        settle_nx;
   logic [N_IN-1:0]   vec_nx;
   logic [N_IN:0]     err_nx;
   logic              fev_valid_nx;
   logic [N_IN-1:0]   fev_nx;

   // Sweep index to applied vector: Gray order for hazard sweeps, otherwise plain binary.
   function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_EN
      return i ^ (i >> 1);
`else
      return i;
`endif
   endfunction

   assign idx_inc = idx + 1'b1;

   // State register; reset aborts any sweep in progress without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and next-datapath values; everything holds unless a state acts on it.
   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      settle_nx    = settle_cnt;
      vec_nx       = vec_out;
      err_nx       = err_count;
      fev_valid_nx = first_err_valid;
      fev_nx       = first_err_vec;
      case (state)
         S_IDLE: begin
            if (start) begin
               err_nx       = '0;
               fev_valid_nx = 1'b0;
               fev_nx       = '0;
               idx_nx       = '0;
               vec_nx       = map_vec('0);
               settle_nx    = SETTLE_INIT;
               state_nx     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (settle_cnt == 8'd0) begin
               state_nx = S_CHECK;
            end else begin
               settle_nx = settle_cnt - 8'd1;
            end
         end
         S_CHECK: begin
            if (dut_f != gold_f) begin
               err_nx = err_count + 1'b1;
               if (!first_err_valid) begin
                  fev_valid_nx = 1'b1;
                  fev_nx       = vec_out;
               end
            end
            if (idx == IDX_LAST) begin
               state_nx = S_DONE;
            end else begin
               idx_nx    = idx_inc;
               vec_nx    = map_vec(idx_inc);
               settle_nx = SETTLE_INIT;
               state_nx  = S_WAIT;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Datapath registers: sweep position, settle timer, stimulus and results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx             <= '0;
         settle_cnt      <= 8'd0;
         vec_out         <= '0;
         err_count       <= '0;
         first_err_valid <= 1'b0;
         first_err_vec   <= '0;
      end else begin
         idx             <= idx_nx;
         settle_cnt      <= settle_nx;
         vec_out         <= vec_nx;
         err_count       <= err_nx;
         first_err_valid <= fev_valid_nx;
         first_err_vec   <= fev_nx;
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
// tb_exhaustive_vector_sweeper
// Two sweepers share clock and reset: one with SETTLE=1, one with SETTLE=0.
// The DUT and golden outputs fed back to each sweeper come from 8-entry truth
// tables held in the bench; expected results come from walking those tables in
// the sweep order (binary, or Gray when SWEEP_GRAY_EN is defined).
module tb_exhaustive_vector_sweeper;

   localparam int NV = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       sel;
   logic [7:0] gold_tt;
   logic [7:0] dut_tt;

   logic [2:0] vec_a, vec_b, fev_a, fev_b;
   logic       busy_a, busy_b, done_a, done_b, fv_a, fv_b;
   logic [3:0] err_a, err_b;
   logic       dut_fa, dut_fb, gold_fa, gold_fb;

   logic [2:0] obs_vec, obs_fev;
   logic       obs_busy, obs_done, obs_fv;
   logic [3:0] obs_err;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   assign gold_fa = gold_tt[vec_a];
   assign dut_fa  = dut_tt[vec_a];
   assign gold_fb = gold_tt[vec_b];
   assign dut_fb  = dut_tt[vec_b];

   exhaustive_vector_sweeper #(.N_IN(3), .N_OUT(1), .SETTLE(1)) u_sweep_a (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel), .vec_out(vec_a),
      .dut_f(dut_fa), .gold_f(gold_fa), .busy(busy_a), .done(done_a),
      .err_count(err_a), .first_err_valid(fv_a), .first_err_vec(fev_a));

   exhaustive_vector_sweeper #(.N_IN(3), .N_OUT(1), .SETTLE(0)) u_sweep_b (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .vec_out(vec_b),
      .dut_f(dut_fb), .gold_f(gold_fb), .busy(busy_b), .done(done_b),
      .err_count(err_b), .first_err_valid(fv_b), .first_err_vec(fev_b));

   assign obs_vec  = sel ? vec_b  : vec_a;
   assign obs_fev  = sel ? fev_b  : fev_a;
   assign obs_busy = sel ? busy_b : busy_a;
   assign obs_done = sel ? done_b : done_a;
   assign obs_fv   = sel ? fv_b   : fv_a;
   assign obs_err  = sel ? err_b  : err_a;

   // Sweep position to applied vector in the order the build uses.
   function automatic logic [2:0] mapv(input int i);
`ifdef SWEEP_GRAY_EN
      return 3'(i ^ (i >> 1));
`else
      return 3'(i);
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // mode 0 clean, 1 gold=a&b|c vs dut=a|b|c, 2 dut=~gold, 3 random tables
   task automatic applyStimulus(input int mode);
      logic a, b, c;
      case (mode)
         0: begin gold_tt = 8'($urandom); dut_tt = gold_tt; end
         1: begin
            for (int v = 0; v < NV; v++) begin
               a = v[2]; b = v[1]; c = v[0];
               gold_tt[v] = (a & b) | c;
               dut_tt[v]  = a | b | c;
            end
         end
         2: begin gold_tt = 8'($urandom); dut_tt = ~gold_tt; end
         default: begin gold_tt = 8'($urandom); dut_tt = 8'($urandom); end
      endcase
   endtask

   task automatic expectedResults(output int ecnt, output logic evalid, output logic [2:0] efirst);
      logic [2:0] v;
      ecnt = 0; evalid = 1'b0; efirst = 3'd0;
      for (int i = 0; i < NV; i++) begin
         v = mapv(i);
         if (gold_tt[v] != dut_tt[v]) begin
            if (!evalid) begin evalid = 1'b1; efirst = v; end
            ecnt++;
         end
      end
   endtask

   task automatic checkZeros(input string tag);
      checkOutput({tag, "_vec"},  32'(obs_vec), 32'd0);
      checkOutput({tag, "_busy"}, 32'(obs_busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(obs_done), 32'd0);
      checkOutput({tag, "_err"},  32'(obs_err), 32'd0);
      checkOutput({tag, "_fv"},   32'(obs_fv), 32'd0);
      checkOutput({tag, "_fev"},  32'(obs_fev), 32'd0);
   endtask

   // One sweep checked cycle by cycle; k counts cycles after the edge that accepted start.
   task automatic runSweep(input int settle, input int repulse_at, input int reset_at, input bit hold);
      int         p, total, ecnt;
      logic       evalid;
      logic [2:0] efirst;
      p = settle + 2;
      total = NV * p;
      expectedResults(ecnt, evalid, efirst);
      @(negedge clk) start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      for (int k = 0; k <= total; k++) begin
         if (k > 0) @(negedge clk);
         if (!hold && k == repulse_at) start = 1'b1;
         if (!hold && k == repulse_at + 1) start = 1'b0;
         if (k == reset_at) begin
            rst_n = 1'b0;
            #1;
            checkZeros("mid_reset");
            @(negedge clk) rst_n = 1'b1;
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               checkOutput("post_reset_done", 32'(obs_done), 32'd0);
               checkOutput("post_reset_busy", 32'(obs_busy), 32'd0);
            end
            return;
         end
         if (k < total) begin
            checkOutput("sweep_vec",  32'(obs_vec),  32'(mapv(k / p)));
            checkOutput("sweep_busy", 32'(obs_busy), 32'd1);
            checkOutput("sweep_done", 32'(obs_done), 32'd0);
         end else begin
            checkOutput("done_pulse", 32'(obs_done), 32'd1);
            checkOutput("done_busy",  32'(obs_busy), 32'd1);
            checkOutput("err_count",  32'(obs_err),  32'(ecnt));
            checkOutput("first_valid", 32'(obs_fv),  32'(evalid));
            checkOutput("first_vec",  32'(obs_fev),  32'(efirst));
         end
      end
      if (!hold) begin
         @(negedge clk);
         checkOutput("idle_done", 32'(obs_done), 32'd0);
         checkOutput("idle_busy", 32'(obs_busy), 32'd0);
         checkOutput("idle_err",  32'(obs_err),  32'(ecnt));
         checkOutput("idle_fev",  32'(obs_fev),  32'(efirst));
      end
   endtask

   // Main sequence of scenarios.
   initial begin
      int waited;
      rst_n = 1'b0;
      start = 1'b0;
      sel   = 1'b0;
      gold_tt = 8'd0;
      dut_tt  = 8'd0;
      repeat (2) @(negedge clk);
      checkZeros("in_reset");
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkZeros("reset_idle");
      end

      applyStimulus(0); runSweep(1, -1, -1, 1'b0);
      applyStimulus(1); runSweep(1, -1, -1, 1'b0);
      applyStimulus(2); runSweep(1, -1, -1, 1'b0);
      applyStimulus(1); runSweep(1, 10, -1, 1'b0);
      applyStimulus(1); runSweep(1, -1, 12, 1'b0);
      applyStimulus(0); runSweep(1, -1, -1, 1'b0);

      sel = 1'b1;
      applyStimulus(1); runSweep(0, -1, -1, 1'b0);
      applyStimulus(1); runSweep(0, -1, 5, 1'b0);
      applyStimulus(0); runSweep(0, -1, -1, 1'b0);
      sel = 1'b0;

      for (int r = 0; r < 6; r++) begin
         sel = 1'($urandom);
         applyStimulus(3);
         runSweep(sel ? 0 : 1, -1, -1, 1'b0);
      end
      sel = 1'b0;

      applyStimulus(2);
      runSweep(1, -1, -1, 1'b1);
      @(negedge clk);
      checkOutput("hold_gap_busy", 32'(obs_busy), 32'd0);
      checkOutput("hold_gap_err",  32'(obs_err),  32'd8);
      applyStimulus(0);
      @(negedge clk);
      start = 1'b0;
      checkOutput("hold_restart_busy", 32'(obs_busy), 32'd1);
      checkOutput("hold_restart_err",  32'(obs_err),  32'd0);
      checkOutput("hold_restart_fv",   32'(obs_fv),   32'd0);
      checkOutput("hold_restart_vec",  32'(obs_vec),  32'(mapv(0)));
      waited = 0;
      while (obs_busy && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("hold_second_finished", 32'(obs_busy), 32'd0);
      checkOutput("hold_second_err",      32'(obs_err),  32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
